// File: rtl/fmc_apb_initiator_pkg.sv
// Shared types and constants for the APB-to-FMC initiator.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
package fmc_apb_initiator_pkg;

   localparam int FMC_DATA_WIDTH         = 16;
   localparam int FMC_AHI_WIDTH          = 7;
   localparam int DEFAULT_DATA_LATENCY   = 2;
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LAT,
      ST_DATA0,
      ST_DATA1,
      ST_DONE
   } fmc_state_e;

   // Everything the initiator drives onto the FMC bus, except the clock.
   typedef struct packed {
      logic                      ne;
      logic                      nadv;
      logic                      nwe;
      logic                      noe;
      logic [1:0]                nbl;
      logic [FMC_AHI_WIDTH-1:0]  a_hi;
      logic [FMC_DATA_WIDTH-1:0] ad_out;
      logic                      ad_oe;
   } fmc_pins_t;

   // The part of the APB request still needed after the address phase.
   typedef struct packed {
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } apb_req_t;

   localparam fmc_pins_t PINS_RESET = '{
      ne:     1'b1,
      nadv:   1'b1,
      nwe:    1'b1,
      noe:    1'b1,
      nbl:    2'b11,
      a_hi:   '0,
      ad_out: '0,
      ad_oe:  1'b0
   };

   // End-of-burst pin state: strobes released, AD turned around, the last
   // address and data values left on the pins.
   function automatic fmc_pins_t release_bus(input fmc_pins_t p);
      fmc_pins_t r;
      r       = p;
      r.ne    = 1'b1;
      r.noe   = 1'b1;
      r.nwe   = 1'b1;
      r.nbl   = 2'b11;
      r.ad_oe = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/fmc_initiator_clkgen.sv
// FMC clock generator: pclk/2 while active, held low otherwise, plus a fall strobe.
// Latency: fmc_clk rises on the first pclk edge after active goes high.
// Backpressure: none; fall is high during the pclk cycle whose closing edge drives fmc_clk 1->0.
//
// Ports:
//   pclk, preset_n  clock and synchronous active-low reset
//   active          toggle enable; when low fmc_clk returns low on the next edge
//   fmc_clk         generated FMC clock
//   fall            one-pclk strobe qualifying the edge on which FMC outputs move
module fmc_initiator_clkgen (
   input  logic pclk,
   input  logic preset_n,
   input  logic active,
   output logic fmc_clk,
   output logic fall
);

   logic clk_q;

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         clk_q <= 1'b0;
      end else begin
         clk_q <= active ? ~clk_q : 1'b0;
      end
   end

   assign fmc_clk = clk_q;
   assign fall    = active & clk_q;

endmodule

// File: rtl/fmc_apb_initiator.sv
// APB completer turning each 32-bit access into one multiplexed 16-bit FMC burst.
// Latency: pready on cycle 2*(3+DATA_LATENCY)+1 after the first psel&&penable cycle, +2 pclk per FMC wait cycle.
// Backpressure: APB wait states via pready; fmc_nwait low stalls the current data beat indefinitely.
//
// Optional feature macro: FMC_APB_INITIATOR_TIMEOUT_EN (aborts a wait longer
// than TIMEOUT_CYCLES pclk with pready+pslverr).
//
// Ports:
//   pclk, preset_n                      clock, synchronous active-low reset
//   psel/penable/pwrite/paddr/pwdata/pstrb, pready/prdata/pslverr   APB completer
//   fmc_clk_out                         FMC clock, pclk/2 during a burst, low when idle
//   fmc_ne/fmc_nl_nadv/fmc_nwe/fmc_noe/fmc_nbl   FMC strobes, active low
//   fmc_a_hi                            upper address paddr[23:17]
//   fmc_ad_out/fmc_ad_oe/fmc_ad_in      multiplexed AD bus, tristate split
//   fmc_nwait                           target wait, active low
module fmc_apb_initiator
   import fmc_apb_initiator_pkg::*;
#(
   parameter int unsigned DATA_LATENCY = DEFAULT_DATA_LATENCY
`ifdef FMC_APB_INITIATOR_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
   input  logic                      pclk,
   input  logic                      preset_n,
   input  logic                      psel,
   input  logic                      penable,
   input  logic                      pwrite,
   input  logic [23:0]               paddr,
   input  logic [31:0]               pwdata,
   input  logic [3:0]                pstrb,
   output logic                      pready,
   output logic [31:0]               prdata,
   output logic                      pslverr,
   output logic                      fmc_clk_out,
   output logic                      fmc_ne,
   output logic                      fmc_nl_nadv,
   output logic                      fmc_nwe,
   output logic                      fmc_noe,
   output logic [1:0]                fmc_nbl,
   output logic [FMC_AHI_WIDTH-1:0]  fmc_a_hi,
   output logic [FMC_DATA_WIDTH-1:0] fmc_ad_out,
   output logic                      fmc_ad_oe,
   input  logic [FMC_DATA_WIDTH-1:0] fmc_ad_in,
   input  logic                      fmc_nwait
);

   localparam logic [3:0] LAT_LAST = 4'(DATA_LATENCY - 1);

   fmc_state_e state_q, state_d;
   apb_req_t   req_q, req_d;
   fmc_pins_t  pins_q, pins_d;
   logic [3:0] lat_q, lat_d;
   logic       pready_q, pready_d;
   logic [31:0] prdata_q, prdata_d;

   logic busy;
   logic fall;
   logic beat_done;
   logic to_hit;

   // Byte-address bit 0 never reaches the halfword-addressed FMC bus.
   logic unused_paddr0;
   assign unused_paddr0 = paddr[0];

   assign busy      = (state_q == ST_ADDR) || (state_q == ST_LAT) ||
                      (state_q == ST_DATA0) || (state_q == ST_DATA1);
   assign beat_done = fall && fmc_nwait;

   // An aborted burst must land in DONE with the FMC clock already low, so
   // the abort also stops the clock on that same edge.
   fmc_initiator_clkgen u_clkgen (
      .pclk     (pclk),
      .preset_n (preset_n),
      .active   (busy && !to_hit),
      .fmc_clk  (fmc_clk_out),
      .fall     (fall)
   );

`ifdef FMC_APB_INITIATOR_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_q;
   logic            stalled;
   logic            pslverr_q;

   assign stalled = ((state_q == ST_DATA0) || (state_q == ST_DATA1)) && !fmc_nwait;
   // Fires on the stalled edge that takes the count to TIMEOUT_CYCLES.
   assign to_hit  = stalled && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk) begin
      if (!preset_n || !((state_q == ST_DATA0) || (state_q == ST_DATA1)) || beat_done) begin
         to_cnt_q <= '0;
      end else if (!fmc_nwait) begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end

   // The abort edge is the only way into DONE with an error, so the error
   // flag simply follows it for the single DONE cycle.
   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         pslverr_q <= 1'b0;
      end else begin
         pslverr_q <= to_hit;
      end
   end

   assign pslverr = pslverr_q;
`else
   assign to_hit  = 1'b0;
   assign pslverr = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         state_q  <= ST_IDLE;
         req_q    <= '0;
         pins_q   <= PINS_RESET;
         lat_q    <= '0;
         pready_q <= 1'b0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         pins_q   <= pins_d;
         lat_q    <= lat_d;
         pready_q <= pready_d;
         prdata_q <= prdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      pins_d   = pins_q;
      lat_d    = lat_q;
      pready_d = 1'b0;
      prdata_d = prdata_q;

      case (state_q)
         ST_IDLE: begin
            // The address phase is driven straight from the APB inputs on
            // the accepting edge; only write data and strobes are kept.
            if (psel && penable && !pready_q) begin
               req_d.write   = pwrite;
               req_d.wdata   = pwdata;
               req_d.strb    = pstrb;
               pins_d.ne     = 1'b0;
               pins_d.nadv   = 1'b0;
               pins_d.nwe    = ~pwrite;
               pins_d.ad_out = paddr[16:1];
               pins_d.ad_oe  = 1'b1;
               pins_d.a_hi   = paddr[23:17];
               state_d       = ST_ADDR;
            end
         end

         ST_ADDR: begin
            if (fall) begin
               pins_d.nadv = 1'b1;
               if (req_q.write) begin
                  pins_d.ad_out = req_q.wdata[15:0];
                  pins_d.nbl    = ~req_q.strb[1:0];
               end else begin
                  pins_d.ad_oe = 1'b0;
                  pins_d.noe   = 1'b0;
                  pins_d.nbl   = 2'b00;
               end
               lat_d   = '0;
               state_d = ST_LAT;
            end
         end

         ST_LAT: begin
            if (fall) begin
               if (lat_q == LAT_LAST) begin
                  state_d = ST_DATA0;
               end else begin
                  lat_d = lat_q + 4'd1;
               end
            end
         end

         ST_DATA0: begin
            if (beat_done) begin
               if (req_q.write) begin
                  pins_d.ad_out = req_q.wdata[31:16];
                  pins_d.nbl    = ~req_q.strb[3:2];
               end else begin
                  prdata_d[15:0] = fmc_ad_in;
               end
               state_d = ST_DATA1;
            end
         end

         ST_DATA1: begin
            if (beat_done) begin
               if (!req_q.write) begin
                  prdata_d[31:16] = fmc_ad_in;
               end
               pins_d   = release_bus(pins_q);
               pready_d = 1'b1;
               state_d  = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort overrides whatever the data beat would have done; halfwords
      // that were never captured read back as zero.
      if (to_hit) begin
         if (!req_q.write) begin
            if (state_q == ST_DATA0) begin
               prdata_d = '0;
            end else begin
               prdata_d = {16'h0000, prdata_q[15:0]};
            end
         end
         pins_d   = release_bus(pins_q);
         pready_d = 1'b1;
         state_d  = ST_DONE;
      end
   end

   assign pready      = pready_q;
   assign prdata      = prdata_q;
   assign fmc_ne      = pins_q.ne;
   assign fmc_nl_nadv = pins_q.nadv;
   assign fmc_nwe     = pins_q.nwe;
   assign fmc_noe     = pins_q.noe;
   assign fmc_nbl     = pins_q.nbl;
   assign fmc_a_hi    = pins_q.a_hi;
   assign fmc_ad_out  = pins_q.ad_out;
   assign fmc_ad_oe   = pins_q.ad_oe;

endmodule

// File: tb/tb_fmc_apb_initiator.sv
// Self-checking bench for fmc_apb_initiator: directed cases then random APB
// accesses, checked cycle by cycle against a timeline model of the FMC burst.
module tb_fmc_apb_initiator;

   localparam int L = 2;

   logic        pclk = 1'b0;
   logic        preset_n;
   logic        psel, penable, pwrite;
   logic [23:0] paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        fmc_clk_out, fmc_ne, fmc_nl_nadv, fmc_nwe, fmc_noe, fmc_ad_oe;
   logic [1:0]  fmc_nbl;
   logic [6:0]  fmc_a_hi;
   logic [15:0] fmc_ad_out, fmc_ad_in;
   logic        fmc_nwait;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] last_rd;

   always #10 pclk = ~pclk;

`ifdef FMC_APB_INITIATOR_TIMEOUT_EN
   fmc_apb_initiator #(.DATA_LATENCY(L), .TIMEOUT_CYCLES(16)) dut (
`else
   fmc_apb_initiator #(.DATA_LATENCY(L)) dut (
`endif
      .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .fmc_clk_out(fmc_clk_out), .fmc_ne(fmc_ne), .fmc_nl_nadv(fmc_nl_nadv),
      .fmc_nwe(fmc_nwe), .fmc_noe(fmc_noe), .fmc_nbl(fmc_nbl),
      .fmc_a_hi(fmc_a_hi), .fmc_ad_out(fmc_ad_out), .fmc_ad_oe(fmc_ad_oe),
      .fmc_ad_in(fmc_ad_in), .fmc_nwait(fmc_nwait)
   );

   // {clk, ne, nadv, nwe, noe, ad_oe, nbl[1:0], pready, pslverr}
   logic [9:0] ctl;
   assign ctl = {fmc_clk_out, fmc_ne, fmc_nl_nadv, fmc_nwe, fmc_noe, fmc_ad_oe,
                 fmc_nbl, pready, pslverr};
   localparam logic [9:0] IDLE_CTL = 10'b0_1_1_1_1_0_11_0_0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One APB access. Cycle 0 is the first psel&&penable cycle. w0/w1 are the
   // number of FMC cycles the target holds nwait low in each data beat.
   // rst_at >= 0 pulses reset during that cycle instead of finishing.
   task automatic xfer(input bit wr, input logic [23:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic [15:0] lo, input logic [15:0] hi,
                       input int w0, input int w1, input int rst_at);
      int lat_end, d0_end, d1_end, rdy;
      bit busy, addr_ph, d1_ph;
      logic [1:0] e_nbl;
      logic [9:0] e_ctl;
      lat_end = 2 + 2 * L;
      d0_end  = lat_end + 2 * (w0 + 1);
      d1_end  = d0_end + 2 * (w1 + 1);
      rdy     = d1_end + 1;

      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
      fmc_nwait = 1'b1; fmc_ad_in = 16'($urandom);
      @(negedge pclk);
      check("setup_ctl", ctl, IDLE_CTL);

      for (int c = 0; c <= rdy; c++) begin
         @(posedge pclk); #1;
         if (c == 0) penable = 1'b1;
         if (c == rst_at) preset_n = 1'b0;
         fmc_nwait = !((c > lat_end && c <= lat_end + 2 * w0) ||
                       (c > d0_end && c <= d0_end + 2 * w1));
         fmc_ad_in = (c <= d0_end) ? lo : hi;
         @(negedge pclk);

         busy    = (c >= 1 && c <= d1_end);
         addr_ph = (c >= 1 && c <= 2);
         d1_ph   = (c > d0_end && c <= d1_end);
         if (!busy || addr_ph) e_nbl = 2'b11;
         else if (!wr)         e_nbl = 2'b00;
         else if (d1_ph)       e_nbl = ~st[3:2];
         else                  e_nbl = ~st[1:0];
         e_ctl = {busy && (c % 2 == 0), !busy, !addr_ph, !(busy && wr),
                  !(busy && !addr_ph && !wr), addr_ph || (busy && wr),
                  e_nbl, c == rdy, 1'b0};
         check($sformatf("ctl c%0d", c), ctl, e_ctl);
         if (busy) check("a_hi", fmc_a_hi, addr[23:17]);
         if (addr_ph)
            check("ad_addr", fmc_ad_out, (addr >> 1) & 24'hFFFF);
         else if (busy && wr)
            check("ad_wdata", fmc_ad_out, d1_ph ? (wd >> 16) : (wd & 32'hFFFF));
         if (c == rdy) begin
            if (!wr) last_rd = {hi, lo};
            check("prdata", prdata, last_rd);
         end
         if (c == rst_at) break;
      end

      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; fmc_nwait = 1'b1;
      if (rst_at >= 0) begin
         preset_n = 1'b1;
         last_rd  = '0;
         @(negedge pclk);
         check("rst_ctl", ctl, IDLE_CTL);
         check("rst_prdata", prdata, 32'h0);
         check("rst_ahi_ad", {fmc_a_hi, fmc_ad_out}, 23'h0);
         repeat (4) begin
            @(negedge pclk);
            check("rst_idle", ctl, IDLE_CTL);
         end
      end else begin
         @(negedge pclk);
         check("post_ctl", ctl, IDLE_CTL);
         check("prdata_hold", prdata, last_rd);
      end
   endtask

`ifdef FMC_APB_INITIATOR_TIMEOUT_EN
   // Read with nwait stuck low: stalled cycles start at cycle 2+2L+1 and the
   // 16th stalled edge raises pready/pslverr.
   task automatic xfer_timeout(input logic [23:0] addr);
      int seen;
      int exp_c;
      seen  = -1;
      exp_c = 2 + 2 * L + 1 + 16;
      @(posedge pclk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; pstrb = 4'hF;
      fmc_nwait = 1'b0;
      for (int c = 0; c < 60 && seen < 0; c++) begin
         @(posedge pclk); #1;
         penable = 1'b1;
         @(negedge pclk);
         if (pready) begin
            seen = c;
            check("to_err", pslverr, 1'b1);
            check("to_prdata", prdata, 32'h0);
            check("to_ne_clk", {fmc_ne, fmc_clk_out}, 2'b10);
         end
      end
      check("to_cycle", seen, exp_c);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0; fmc_nwait = 1'b1;
      last_rd = '0;
      @(negedge pclk);
      check("to_post", ctl, IDLE_CTL);
   endtask
`endif

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      preset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; fmc_ad_in = '0; fmc_nwait = 1'b1;
      last_rd = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("reset_ctl", ctl, IDLE_CTL);
      check("reset_prdata", prdata, 32'h0);
      check("reset_ahi_ad", {fmc_a_hi, fmc_ad_out}, 23'h0);
      @(posedge pclk); #1;
      preset_n = 1'b1;

      xfer(1'b0, 24'h123458, 32'h0, 4'hF, 16'hBEEF, 16'hCAFE, 0, 0, -1);
      check("rd_directed", last_rd, 32'hCAFEBEEF);
      xfer(1'b1, 24'h00_0100, 32'hA5A5_5A5A, 4'b0110, 16'h0, 16'h0, 0, 0, -1);
      xfer(1'b0, 24'h7F_FFFC, 32'h0, 4'hF, 16'h1234, 16'h5678, 3, 0, -1);
      xfer(1'b0, 24'h40_0008, 32'h0, 4'hF, 16'h1111, 16'h2222, 0, 0, 8);
      xfer(1'b0, 24'h40_0008, 32'h0, 4'hF, 16'h3333, 16'h4444, 0, 0, -1);
      xfer(1'b1, 24'h01_2344, 32'hDEAD_BEEF, 4'b0000, 16'h0, 16'h0, 0, 2, -1);
      xfer(1'b0, 24'h01_2344, 32'h0, 4'b0000, 16'h9ABC, 16'hDEF0, 1, 1, -1);
      xfer(1'b0, 24'h02_0000, 32'h0, 4'hF, 16'h0F0F, 16'hF0F0, 0, 0, -1);
`ifdef FMC_APB_INITIATOR_TIMEOUT_EN
      xfer_timeout(24'h00_1000);
      xfer(1'b0, 24'h00_1000, 32'h0, 4'hF, 16'hAAAA, 16'h5555, 0, 0, -1);
`endif
      for (int i = 0; i < 40; i++) begin
         xfer(1'($urandom_range(0, 1)), 24'($urandom), $urandom, 4'($urandom),
              16'($urandom), 16'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
